// File: rtl/user_wb_pkg.sv
// Shared constants for the Wishbone counter slice:
// register offsets, bit positions and the default region base.
package user_wb_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

    localparam logic [11:0] OFF_COUNT  = 12'h000;
    localparam logic [11:0] OFF_CTRL   = 12'h004;
    localparam logic [11:0] OFF_STATUS = 12'h008;

    localparam int CTRL_EN_BIT     = 0;
    localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/wb_slave_if.sv
// Classic single-cycle Wishbone slave front end: region decode,
// one-cycle ack and per-bit write enables expanded from byte selects.
module wb_slave_if
    import user_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    output logic        ack,
    output logic        req,
    output logic        wr,
    output logic [11:0] offset,
    output logic [31:0] byte_we
);

    logic hit;

    assign hit    = (adr[31:12] == BASE_ADDR[31:12]);
    // ~ack keeps a held strobe from being accepted twice in a row
    assign req    = cyc & stb & hit & ~ack;
    assign wr     = req & we;
    assign offset = adr[11:0];

    always_comb begin
        byte_we = '0;
        for (int b = 0; b < 4; b++) begin
            byte_we[b*8 +: 8] = {8{wr & sel[b]}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack <= 1'b0;
        end else begin
            ack <= req;
        end
    end

endmodule

// File: rtl/user_wb_counter.sv
// Wishbone-mapped free-running counter with load, enable and a
// sticky wrap flag; count drives the user pads, wrap drives irq[0].
module user_wb_counter
    import user_wb_pkg::*;
#(
    parameter int          BITS      = 32,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  irq
);

    logic            req;
    logic            wr;
    logic [11:0]     offset;
    logic [31:0]     byte_we;
    logic [BITS-1:0] count;
    logic [BITS-1:0] lane;
    logic            en;
    logic            wrap;
    logic [31:0]     count_ext;
    logic [31:0]     rdata;
    logic            cnt_wr;
    logic            ctrl_wr;
    logic            stat_clr;
    logic            inc;
    logic            wrap_set;
    logic            unused_bits;

    wb_slave_if #(
        .BASE_ADDR(BASE_ADDR)
    ) u_if (
        .clock  (wb_clk_i),
        .reset  (wb_rst_i),
        .cyc    (wbs_cyc_i),
        .stb    (wbs_stb_i),
        .we     (wbs_we_i),
        .sel    (wbs_sel_i),
        .adr    (wbs_adr_i),
        .ack    (wbs_ack_o),
        .req    (req),
        .wr     (wr),
        .offset (offset),
        .byte_we(byte_we)
    );

    assign lane      = byte_we[BITS-1:0];
    assign cnt_wr    = wr && (offset == OFF_COUNT);
    assign ctrl_wr   = wr && (offset == OFF_CTRL) && byte_we[CTRL_EN_BIT];
    assign stat_clr  = wr && (offset == OFF_STATUS)
                     && byte_we[STATUS_WRAP_BIT]
                     && wbs_dat_i[STATUS_WRAP_BIT];
    // a COUNT load replaces the increment for that cycle
    assign inc       = en & ~cnt_wr;
    assign wrap_set  = inc & (&count);
    assign count_ext = 32'(count);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (offset == OFF_COUNT):  rdata = count_ext;
            (offset == OFF_CTRL):   rdata[CTRL_EN_BIT] = en;
            (offset == OFF_STATUS): rdata[STATUS_WRAP_BIT] = wrap;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count     <= '0;
            en        <= 1'b1;
            wrap      <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            if (cnt_wr) begin
                count <= (count & ~lane) | (wbs_dat_i[BITS-1:0] & lane);
            end else if (inc) begin
                count <= count + BITS'(1);
            end
            if (ctrl_wr) begin
                en <= wbs_dat_i[CTRL_EN_BIT];
            end
            // setting beats a simultaneous write-1-to-clear
            if (wrap_set) begin
                wrap <= 1'b1;
            end else if (stat_clr) begin
                wrap <= 1'b0;
            end
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
        end
    end

    assign io_out = {6'b0, count_ext};
    assign io_oeb = {38{wb_rst_i}};
    assign irq    = {2'b00, wrap};

    assign unused_bits = ^{io_in, wbs_dat_i, byte_we};

endmodule

// File: tb/tb_user_wb_counter.sv
// Scoreboard bench for user_wb_counter: read expectations are queued
// at issue and popped by a monitor when the slave acks.
module tb_user_wb_counter;

    localparam logic [31:0] A_COUNT  = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = 32'h3000_0004;
    localparam logic [31:0] A_STATUS = 32'h3000_0008;

    typedef struct {
        string       tag;
        bit          rd;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [37:0] io_in;
    logic [37:0] io_out, io_oeb;
    logic [2:0]  irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         sb[$];
    logic [31:0] m_cnt;
    bit          m_en;

    user_wb_counter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [37:0] got,
                         input logic [37:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.rd) check(e.tag, wbs_dat_o, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (m_en) m_cnt++;
        end
    endtask

    // called at a negedge; returns at a negedge with the bus idle
    task automatic wb_io(input string tag, input bit w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit exp_ack,
                         input logic [31:0] exp_rd);
        bit got;
        int lat;
        sb_t e;
        got = 0;
        lat = 0;
        if (exp_ack) begin
            e.tag  = tag;
            e.rd   = !w;
            e.data = exp_rd;
            sb.push_back(e);
        end
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        for (int i = 1; i <= 16 && !got; i++) begin
            @(negedge clk);
            lat = i;
            if (i == 1 && exp_ack && w && a[11:0] == 12'h000) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_cnt[b*8 +: 8] = d[b*8 +: 8];
            end else begin
                if (m_en) m_cnt++;
                if (i == 1 && exp_ack && w && a[11:0] == 12'h004 && s[0])
                    m_en = d[0];
            end
            if (wbs_ack_o) got = 1;
        end
        cyc = 0; stb = 0; we = 0;
        check({tag, "_ack"}, got, exp_ack);
        if (exp_ack) check({tag, "_lat"}, lat, 1);
        tick(1);
        check({tag, "_idle"}, {wbs_ack_o, wbs_dat_o}, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        wb_io(tag, 0, a, 0, 4'hF, 1, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        wb_io(tag, 1, a, d, s, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a1, a2, a3;
        sb_t e;
        logic [31:0] c0;
        rst = 1; cyc = 0; stb = 0; we = 0;
        sel = 0; adr = 0; dat = 0; io_in = '0;
        m_cnt = 0; m_en = 1;

        repeat (5) @(negedge clk);
        check("rst_count", io_out, 0);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
        check("rst_irq", irq, 0);
        rst = 0;
        #1;
        check("run_oeb", io_oeb, 0);
        @(negedge clk);
        tick(9);
        m_cnt = 10;
        check("cnt10_pad", io_out, 38'hA);
        rd("cnt10", A_COUNT, 32'hA);

        wr("load", A_COUNT, 32'h0000_AB60, 4'hF);
        rd("load_rd", A_COUNT, 32'hAB61);
        tick(4);
        check("pad_track", io_out[15:0], 16'hAB67);
        rd("load_rd2", A_COUNT, m_cnt);

        wr("stop", A_CTRL, 0, 4'hF);
        rd("stop_rd1", A_COUNT, m_cnt);
        tick(20);
        rd("stop_rd2", A_COUNT, m_cnt);
        rd("ctrl0", A_CTRL, 0);

        wr("ld_base", A_COUNT, 32'h1234_5678, 4'hF);
        wr("ld_lane", A_COUNT, 32'hAABB_CCDD, 4'b0010);
        rd("lane_rd", A_COUNT, 32'h1234_CC78);
        wr("start", A_CTRL, 1, 4'hF);
        rd("resume_rd", A_COUNT, 32'h1234_CC79);
        rd("ctrl1", A_CTRL, 1);

        wr("ld_fe", A_COUNT, 32'hFFFF_FFFE, 4'hF);
        tick(1);
        check("wrap_cnt", io_out, 0);
        check("wrap_irq", irq, 3'b001);
        rd("status1", A_STATUS, 1);
        wr("st_w0", A_STATUS, 0, 4'hF);
        check("w0_irq", irq, 3'b001);
        wr("st_w1", A_STATUS, 1, 4'hF);
        check("clr_irq", irq, 0);
        rd("status0", A_STATUS, 0);

        wr("ld_fe2", A_COUNT, 32'hFFFF_FFFE, 4'hF);
        wr("clr_race", A_STATUS, 1, 4'hF);
        check("set_wins", irq, 3'b001);
        wr("clr2", A_STATUS, 1, 4'hF);
        check("clr2_irq", irq, 0);

        wr("stop2", A_CTRL, 0, 4'hF);
        wr("ld_ff", A_COUNT, 32'hFFFF_FFFF, 4'hF);
        check("ld_ff_irq", irq, 0);
        check("ld_ff_pad", io_out, 38'hFFFF_FFFF);
        wr("start2", A_CTRL, 1, 4'hF);
        check("wrap2_irq", irq, 3'b001);
        check("wrap2_pad", io_out, {6'b0, m_cnt});
        wr("clr3", A_STATUS, 1, 4'hF);

        wb_io("far_rd", 0, 32'h3000_1000, 0, 4'hF, 0, 0);
        wb_io("far_wr", 1, 32'h2000_0000, 0, 4'hF, 0, 0);
        rd("far_chk", A_COUNT, m_cnt);
        rd("hole_rd", 32'h3000_000C, 0);
        wr("hole_wr", 32'h3000_000C, 32'hFFFF_FFFF, 4'hF);
        rd("hole_chk", A_COUNT, m_cnt);
        check("hole_irq", irq, 0);

        c0 = m_cnt;
        e.tag = "held1"; e.rd = 1; e.data = c0;
        sb.push_back(e);
        e.tag = "held2"; e.data = c0 + 2;
        sb.push_back(e);
        cyc = 1; stb = 1; we = 0; adr = A_COUNT; sel = 4'hF;
        @(negedge clk); a1 = wbs_ack_o;
        @(negedge clk); a2 = wbs_ack_o;
        @(negedge clk); a3 = wbs_ack_o;
        cyc = 0; stb = 0;
        m_cnt = c0 + 3;
        tick(1);
        check("held_ack", {a1, a2, a3}, 3'b101);

        cyc = 1; stb = 1; we = 1; adr = A_COUNT; dat = 32'h5555; sel = 4'hF;
        rst = 1;
        @(negedge clk);
        check("rst_mid_ack", wbs_ack_o, 0);
        check("rst_mid_cnt", io_out, 0);
        cyc = 0; stb = 0; we = 0; rst = 0;
        m_cnt = 0; m_en = 1;
        tick(3);
        rd("post_rst", A_COUNT, 32'h3);
        rd("post_ctrl", A_CTRL, 1);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_wb_counter.md
Name: user_wb_counter

Overview:
- Wishbone-slave free-running counter placed in the Caravel user project area; the management SoC reaches it through the Wishbone port at the user base address.
- Firmware can load, start/stop and read back the counter.
- The counter value is driven onto the user I/O pads.
- A sticky wrap flag raises a user interrupt.

Parameters:
- BITS, 32, counter width (1..32); unused upper bits read 0.
- BASE_ADDR, 32'h3000_0000, region base; decode compares adr[31:12] against BASE_ADDR[31:12].

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  38  pad inputs; ignored.
- io_out  out  38  {6'b0, zero-extended count[31:0]}.
- io_oeb  out  38  pad output-enable bar; all 1 while wb_rst_i is high, else all 0.
- irq  out  3  irq[0] = STATUS.wrap; irq[2:1] = 0.

Behaviour:
- Register map (offset = adr[11:0]):
  - 0x00 COUNT: R/W; byte-lane writes per wbs_sel_i.
  - 0x04 CTRL: bit0 en, R/W.
  - 0x08 STATUS: bit0 wrap; read; write-1-to-clear.
  - All other offsets read 0; writes to them are ignored but still acked.
- Reset (sync, wb_rst_i=1 at posedge):
  - count=0, CTRL.en=1, wrap=0, ack=0, dat_o=0.
- Counting:
  - Each posedge with en=1 and no COUNT write: count <= count+1, mod 2^BITS.
  - Transition count all-ones -> 0 sets wrap=1 on that edge.
- Simultaneous events:
  - COUNT write and increment in the same cycle: the write wins; selected bytes are loaded, unselected bytes hold their pre-increment value; no increment that cycle.
  - A write loading all-ones does not itself set wrap.
  - Wrap set and STATUS clear in the same cycle: set wins.
- Handshake (classic single-cycle):
  - ack <= cyc & stb & hit & ~ack; ack is high for exactly one cycle.
  - Read and write take effect on the edge that raises ack, so latency is 1 cycle.
  - dat_o is registered on the same edge; read data is the register value before that edge's update.
  - dat_o returns to 0 when ack is low.
  - A held strobe produces ack every other cycle.
  - Out-of-region address (hit=0): never acked, no side effects.
  - Reset mid-transaction: ack drops immediately; the pending write is discarded.
- Width rules:
  - Bits above BITS-1 in COUNT ignore writes and read 0.
  - CTRL[31:1] and STATUS[31:1] read 0.

Decomposition:
- Shared package user_wb_pkg holds:
  - register offset localparams (OFF_COUNT, OFF_CTRL, OFF_STATUS);
  - CTRL/STATUS bit indices;
  - default BASE_ADDR.
- One natural sub-module, wb_slave_if: address decode, ack generation, per-byte write-strobe expansion.
- Counter and register logic stay in user_wb_counter.

Test Plan:
- Reset check:
  - Hold wb_rst_i 5 cycles -> count=0, ack=0, io_oeb=38'h3F_FFFF_FFFF, irq=0.
  - After release -> io_oeb=0 and count increments, reading 0x0000000A ten cycles after release.
- Load and read:
  - Write COUNT=0x0000AB60 (sel=4'hF) -> ack 1 cycle later.
  - Read COUNT issued N cycles after the write ack returns 0xAB60+N.
  - io_out[15:0] tracks the count.
- Byte-lane write: count=0x12345678, write 0xAABBCCDD with sel=4'b0010 -> count becomes 0x1234CC78 on that edge, then resumes incrementing.
- Stop/start:
  - Write CTRL=0 -> COUNT reads a constant value across 20 cycles.
  - Write CTRL=1 -> counting resumes from the held value.
- Wrap interrupt:
  - Write COUNT=0xFFFFFFFE -> 2 cycles later count=0, irq[0]=1, STATUS reads 1.
  - Write STATUS=1 -> irq[0]=0.
  - Write STATUS=0 -> no effect.
- Decode and handshake:
  - Access to adr 0x3000_1000 or 0x2000_0000 -> no ack within 16 cycles, no state change.
  - Access to offset 0x0C -> ack, read 0.
  - Held stb/cyc -> ack toggles 1,0,1.
